// File: rtl/ndn_spi_link_pkg.sv
// Shared types and constants for the NDN serial link: FSM state enums,
// default field widths and the position of the packet-type bit in meta.
package ndn_link_pkg;

   localparam int DEF_META_W   = 8;
   localparam int DEF_PREFIX_W = 64;
   localparam int DEF_DATA_W   = 256;
   localparam int DEF_NUM_IF   = 4;

   // The packet-type bit sits TYPE_BIT_OFS places below the meta width,
   // i.e. at meta[META_W-2]. 1 = interest (no data field), 0 = data.
   localparam int TYPE_BIT_OFS = 2;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_META   = 3'd2,
      TX_PREFIX = 3'd3,
      TX_DATA   = 3'd4,
      TX_STOP   = 3'd5
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_META   = 3'd1,
      RX_PREFIX = 3'd2,
      RX_DATA   = 3'd3,
      RX_STOP   = 3'd4,
      RX_RESYNC = 3'd5
   } rx_state_e;

   // Bit index of the packet-type flag inside a meta field of width meta_w.
   function automatic int type_bit_idx(input int meta_w);
      return meta_w - TYPE_BIT_OFS;
   endfunction

endpackage

// File: rtl/ndn_spi_link_if.sv
// Parallel-side bundle of the NDN serial link: TX request, RX result and
// FSM state for observation.
//
// Handshake: a TX frame transfers on every rising clk edge where
// tx_valid && tx_ready; tx_if_sel/tx_meta/tx_prefix/tx_data are sampled on
// that edge and may change afterwards. tx_valid while tx_ready is low is
// ignored. rx_valid and rx_err are single-cycle pulses with no back-pressure;
// rx_meta/rx_prefix/rx_data hold the last good frame.
interface ndn_spi_link_if #(
   parameter int META_W   = ndn_link_pkg::DEF_META_W,
   parameter int PREFIX_W = ndn_link_pkg::DEF_PREFIX_W,
   parameter int DATA_W   = ndn_link_pkg::DEF_DATA_W,
   parameter int NUM_IF   = ndn_link_pkg::DEF_NUM_IF
);
   localparam int SEL_W = $clog2(NUM_IF);

   logic                    tx_valid;
   logic                    tx_ready;
   logic [SEL_W-1:0]        tx_if_sel;
   logic [META_W-1:0]       tx_meta;
   logic [PREFIX_W-1:0]     tx_prefix;
   logic [DATA_W-1:0]       tx_data;

   logic                    rx_valid;
   logic                    rx_err;
   logic [META_W-1:0]       rx_meta;
   logic [PREFIX_W-1:0]     rx_prefix;
   logic [DATA_W-1:0]       rx_data;

   ndn_link_pkg::tx_state_e tx_state;
   ndn_link_pkg::rx_state_e rx_state;

   modport master (
      output tx_valid, tx_if_sel, tx_meta, tx_prefix, tx_data,
      input  tx_ready, rx_valid, rx_err, rx_meta, rx_prefix, rx_data,
      input  tx_state, rx_state
   );

   modport slave (
      input  tx_valid, tx_if_sel, tx_meta, tx_prefix, tx_data,
      output tx_ready, rx_valid, rx_err, rx_meta, rx_prefix, rx_data,
      output tx_state, rx_state
   );

endinterface

// File: rtl/ndn_spi_frame_rx.sv
// RX deframer: hunts for a start bit on miso, shifts meta/prefix/(data) MSB
// first into internal registers and publishes them only when the stop bit
// is good. A bad stop bit flags rx_err and waits for the line to go idle.
module ndn_spi_frame_rx
   import ndn_link_pkg::*;
#(
   parameter int META_W   = DEF_META_W,
   parameter int PREFIX_W = DEF_PREFIX_W,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                miso_i,
   output logic                rx_valid_o,
   output logic                rx_err_o,
   output logic [META_W-1:0]   rx_meta_o,
   output logic [PREFIX_W-1:0] rx_prefix_o,
   output logic [DATA_W-1:0]   rx_data_o,
   output rx_state_e           state_o
);
   localparam int CNT_W    = $clog2(DATA_W);
   localparam int TYPE_IDX = type_bit_idx(META_W);

   localparam logic [CNT_W-1:0] META_LAST   = CNT_W'(META_W - 1);
   localparam logic [CNT_W-1:0] PREFIX_LAST = CNT_W'(PREFIX_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   rx_state_e           state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [META_W-1:0]   meta_sr_q, meta_sr_d;
   logic [PREFIX_W-1:0] prefix_sr_q, prefix_sr_d;
   logic [DATA_W-1:0]   data_sr_q, data_sr_d;
   logic [META_W-1:0]   meta_q, meta_d;
   logic [PREFIX_W-1:0] prefix_q, prefix_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;

   // State, shift registers and published frame registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         meta_sr_q   <= '0;
         prefix_sr_q <= '0;
         data_sr_q   <= '0;
         meta_q      <= '0;
         prefix_q    <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         meta_sr_q   <= meta_sr_d;
         prefix_sr_q <= prefix_sr_d;
         data_sr_q   <= data_sr_d;
         meta_q      <= meta_d;
         prefix_q    <= prefix_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   // Next-state logic: walk the frame fields, decide good/bad at the stop bit.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      meta_sr_d   = meta_sr_q;
      prefix_sr_d = prefix_sr_q;
      data_sr_d   = data_sr_q;
      meta_d      = meta_q;
      prefix_d    = prefix_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!miso_i) begin
               state_d = RX_META;
               cnt_d   = META_LAST;
            end
         end
         RX_META: begin
            meta_sr_d = {meta_sr_q[META_W-2:0], miso_i};
            if (cnt_q == '0) begin
               state_d = RX_PREFIX;
               cnt_d   = PREFIX_LAST;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         RX_PREFIX: begin
            prefix_sr_d = {prefix_sr_q[PREFIX_W-2:0], miso_i};
            if (cnt_q == '0) begin
               // meta is complete by now, so its type bit picks the next field.
               if (meta_sr_q[TYPE_IDX]) begin
                  state_d = RX_STOP;
               end else begin
                  state_d = RX_DATA;
                  cnt_d   = DATA_LAST;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         RX_DATA: begin
            data_sr_d = {data_sr_q[DATA_W-2:0], miso_i};
            if (cnt_q == '0) begin
               state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         RX_STOP: begin
            if (miso_i) begin
               meta_d   = meta_sr_q;
               prefix_d = prefix_sr_q;
               // Interests carry no payload; publish zeros rather than stale data.
               data_d   = meta_sr_q[TYPE_IDX] ? '0 : data_sr_q;
               valid_d  = 1'b1;
               state_d  = RX_IDLE;
            end else begin
               err_d   = 1'b1;
               state_d = RX_RESYNC;
            end
         end
         RX_RESYNC: begin
            if (miso_i) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign rx_valid_o  = valid_q;
   assign rx_err_o    = err_q;
   assign rx_meta_o   = meta_q;
   assign rx_prefix_o = prefix_q;
   assign rx_data_o   = data_q;
   assign state_o     = state_q;

endmodule

// File: rtl/ndn_spi_link.sv
// NDN serial link top: TX framer FSM (start, meta, prefix, optional data,
// stop; MSB first, one bit per clk) with chip-select decode, plus the RX
// deframer sub-module. TX and RX share only clk/rst.
module ndn_spi_link
   import ndn_link_pkg::*;
#(
   parameter int META_W   = DEF_META_W,
   parameter int PREFIX_W = DEF_PREFIX_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_IF   = DEF_NUM_IF
) (
   input  logic              clk,
   input  logic              rst,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_IF-1:0] cs_n,
   ndn_spi_link_if.slave     bus
);
   localparam int SEL_W    = $clog2(NUM_IF);
   localparam int CNT_W    = $clog2(DATA_W);
   localparam int TYPE_IDX = type_bit_idx(META_W);

   localparam logic [CNT_W-1:0] META_LAST   = CNT_W'(META_W - 1);
   localparam logic [CNT_W-1:0] PREFIX_LAST = CNT_W'(PREFIX_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   tx_state_e           tx_state_q, tx_state_d;
   logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
   logic [SEL_W-1:0]    tx_sel_q, tx_sel_d;
   logic                tx_type_q, tx_type_d;
   logic [META_W-1:0]   tx_meta_sr_q, tx_meta_sr_d;
   logic [PREFIX_W-1:0] tx_prefix_sr_q, tx_prefix_sr_d;
   logic [DATA_W-1:0]   tx_data_sr_q, tx_data_sr_d;

   assign sclk = clk;

   // TX state register and captured frame shift registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q     <= TX_IDLE;
         tx_cnt_q       <= '0;
         tx_sel_q       <= '0;
         tx_type_q      <= 1'b0;
         tx_meta_sr_q   <= '0;
         tx_prefix_sr_q <= '0;
         tx_data_sr_q   <= '0;
      end else begin
         tx_state_q     <= tx_state_d;
         tx_cnt_q       <= tx_cnt_d;
         tx_sel_q       <= tx_sel_d;
         tx_type_q      <= tx_type_d;
         tx_meta_sr_q   <= tx_meta_sr_d;
         tx_prefix_sr_q <= tx_prefix_sr_d;
         tx_data_sr_q   <= tx_data_sr_d;
      end
   end

   // TX next-state: capture on accept, then shift each field out MSB first.
   always_comb begin
      tx_state_d     = tx_state_q;
      tx_cnt_d       = tx_cnt_q;
      tx_sel_d       = tx_sel_q;
      tx_type_d      = tx_type_q;
      tx_meta_sr_d   = tx_meta_sr_q;
      tx_prefix_sr_d = tx_prefix_sr_q;
      tx_data_sr_d   = tx_data_sr_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (bus.tx_valid) begin
               tx_sel_d       = bus.tx_if_sel;
               tx_type_d      = bus.tx_meta[TYPE_IDX];
               tx_meta_sr_d   = bus.tx_meta;
               tx_prefix_sr_d = bus.tx_prefix;
               tx_data_sr_d   = bus.tx_data;
               tx_state_d     = TX_START;
            end
         end
         TX_START: begin
            tx_state_d = TX_META;
            tx_cnt_d   = META_LAST;
         end
         TX_META: begin
            tx_meta_sr_d = {tx_meta_sr_q[META_W-2:0], 1'b0};
            if (tx_cnt_q == '0) begin
               tx_state_d = TX_PREFIX;
               tx_cnt_d   = PREFIX_LAST;
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         TX_PREFIX: begin
            tx_prefix_sr_d = {tx_prefix_sr_q[PREFIX_W-2:0], 1'b0};
            if (tx_cnt_q == '0) begin
               if (tx_type_q) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_state_d = TX_DATA;
                  tx_cnt_d   = DATA_LAST;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         TX_DATA: begin
            tx_data_sr_d = {tx_data_sr_q[DATA_W-2:0], 1'b0};
            if (tx_cnt_q == '0) begin
               tx_state_d = TX_STOP;
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         // STOP always returns to IDLE: one idle-high bit between frames.
         TX_STOP: tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // TX line decode from the registered state; reset forces idle levels.
   always_comb begin
      mosi = 1'b1;
      cs_n = '1;
      case (tx_state_q)
         TX_START:  mosi = 1'b0;
         TX_META:   mosi = tx_meta_sr_q[META_W-1];
         TX_PREFIX: mosi = tx_prefix_sr_q[PREFIX_W-1];
         TX_DATA:   mosi = tx_data_sr_q[DATA_W-1];
         default:   mosi = 1'b1;
      endcase
      if (tx_state_q != TX_IDLE) cs_n[tx_sel_q] = 1'b0;
   end

   assign bus.tx_ready = (tx_state_q == TX_IDLE);
   assign bus.tx_state = tx_state_q;

   ndn_spi_frame_rx #(
      .META_W   (META_W),
      .PREFIX_W (PREFIX_W),
      .DATA_W   (DATA_W)
   ) u_rx (
      .clk         (clk),
      .rst         (rst),
      .miso_i      (miso),
      .rx_valid_o  (bus.rx_valid),
      .rx_err_o    (bus.rx_err),
      .rx_meta_o   (bus.rx_meta),
      .rx_prefix_o (bus.rx_prefix),
      .rx_data_o   (bus.rx_data),
      .state_o     (bus.rx_state)
   );

endmodule
